// File: rtl/uart_csr_pkg.sv
// Shared definitions for the UART control/status register bank:
// register indices and the default access masks for the standard UART map.
package uart_csr_pkg;

   typedef enum int {
      REG_STAT     = 0,
      REG_CTRL     = 1,
      REG_TX       = 2,
      REG_RX       = 3,
      REG_IRQ_STAT = 4,
      REG_IRQ_EN   = 5
   } csr_idx_e;

   localparam int UART_REG_COUNT  = 6;
   localparam int UART_DATA_WIDTH = 32;
   localparam int UART_MAP_WIDTH  = UART_REG_COUNT * UART_DATA_WIDTH;

   // Concatenations list the highest index first: {IRQ_EN, IRQ_STAT, RX, TX, CTRL, STAT}.
   localparam logic [UART_MAP_WIDTH-1:0] UART_RW_MASK = {
      32'h0000_00FF, 32'h0000_0000, 32'h0000_0000,
      32'h0000_00FF, 32'hFFFF_FFFF, 32'h0000_0000};
   localparam logic [UART_MAP_WIDTH-1:0] UART_RC_MASK = {
      32'h0000_0000, 32'h0000_0000, 32'h0000_0100,
      32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
   localparam logic [UART_MAP_WIDTH-1:0] UART_W1C_MASK = {
      32'h0000_0000, 32'h0000_00FF, 32'h0000_0000,
      32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
   localparam logic [UART_MAP_WIDTH-1:0] UART_RESET_VALUE = {
      32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
      32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

endpackage

// File: rtl/uart_csr_reg.sv
// One CSR word: resolves peripheral set, W1C, read-clear, CPU write and
// peripheral load per bit, in that priority order.
module uart_csr_reg #(
   parameter int                    DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] RW_MASK     = '0,
   parameter logic [DATA_WIDTH-1:0] RC_MASK     = '0,
   parameter logic [DATA_WIDTH-1:0] W1C_MASK    = '0,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cpu_wr,
   input  logic                  cpu_rd,
   input  logic [DATA_WIDTH-1:0] be_mask,
   input  logic [DATA_WIDTH-1:0] cpu_data,
   input  logic                  periph_wr,
   input  logic [DATA_WIDTH-1:0] periph_data,
   input  logic [DATA_WIDTH-1:0] periph_set,
   output logic [DATA_WIDTH-1:0] q
);

   logic [DATA_WIDTH-1:0] load_mask;
   logic [DATA_WIDTH-1:0] write_mask;
   logic [DATA_WIDTH-1:0] clear_mask;
   logic [DATA_WIDTH-1:0] next_q;

   // Layered lowest priority first so each later term overrides the earlier ones.
   always_comb begin
      // NOTE: every always_comb output gets an unconditional default first so no latch is inferred.
      next_q     = q;
      load_mask  = periph_wr ? ~RW_MASK : '0;
      write_mask = cpu_wr ? (be_mask & RW_MASK) : '0;
      clear_mask = (cpu_rd ? RC_MASK : '0)
                 | (cpu_wr ? (be_mask & W1C_MASK & cpu_data) : '0);
      next_q     = (next_q & ~load_mask) | (periph_data & load_mask);
      next_q     = (next_q & ~write_mask) | (cpu_data & write_mask);
      next_q     = (next_q & ~clear_mask) | periph_set;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         q <= RESET_VALUE;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all flops sample the same pre-edge values.
         q <= next_q;
      end
   end

endmodule

// File: rtl/uart_csr_bank.sv
// Parametrised CPU/peripheral CSR bank for the UART: address decode, byte-enable
// expansion, registered read path with error flag, access strobes and masked interrupt.
module uart_csr_bank
   import uart_csr_pkg::*;
#(
   parameter int ADDR_WIDTH   = 3,
   parameter int DATA_WIDTH   = 32,
   parameter int REG_COUNT    = 6,
   parameter logic [REG_COUNT*DATA_WIDTH-1:0] RW_MASK     = '0,
   parameter logic [REG_COUNT*DATA_WIDTH-1:0] RC_MASK     = '0,
   parameter logic [REG_COUNT*DATA_WIDTH-1:0] W1C_MASK    = '0,
   parameter logic [REG_COUNT*DATA_WIDTH-1:0] RESET_VALUE = '0,
   parameter int IRQ_STAT_IDX = int'(REG_IRQ_STAT),
   parameter int IRQ_EN_IDX   = int'(REG_IRQ_EN)
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [ADDR_WIDTH-1:0]           cpu_addr_i,
   input  logic [DATA_WIDTH-1:0]           cpu_data_i,
   input  logic [DATA_WIDTH/8-1:0]         cpu_be_i,
   input  logic                            cpu_wr_en_i,
   input  logic                            cpu_rd_en_i,
   output logic [DATA_WIDTH-1:0]           cpu_data_o,
   output logic                            cpu_rvalid_o,
   output logic                            cpu_err_o,
   input  logic [REG_COUNT*DATA_WIDTH-1:0] periph_data_i,
   input  logic [REG_COUNT-1:0]            periph_wr_en_i,
   input  logic [REG_COUNT*DATA_WIDTH-1:0] periph_set_i,
   output logic [REG_COUNT*DATA_WIDTH-1:0] periph_data_o,
   output logic [REG_COUNT-1:0]            rd_strobe_o,
   output logic [REG_COUNT-1:0]            wr_strobe_o,
   output logic                            irq_o
);

   logic                  addr_ok;
   logic                  rd_req;
   logic                  rd_ok;
   logic                  wr_ok;
   logic [DATA_WIDTH-1:0] be_mask;
   logic [DATA_WIDTH-1:0] rd_mux;
   logic [DATA_WIDTH-1:0] regs [REG_COUNT];
   logic [REG_COUNT-1:0]  rd_sel;
   logic [REG_COUNT-1:0]  wr_sel;

   // A read colliding with a write is dropped; the write still goes ahead.
   assign addr_ok = 32'(cpu_addr_i) < 32'(REG_COUNT);
   assign rd_req  = cpu_rd_en_i & ~cpu_wr_en_i;
   assign rd_ok   = rd_req & addr_ok;
   assign wr_ok   = cpu_wr_en_i & addr_ok;

   for (genvar b = 0; b < DATA_WIDTH / 8; b++) begin : g_be
      assign be_mask[b*8 +: 8] = {8{cpu_be_i[b]}};
   end

   for (genvar r = 0; r < REG_COUNT; r++) begin : g_reg
      assign wr_sel[r] = wr_ok & (cpu_addr_i == ADDR_WIDTH'(r));
      assign rd_sel[r] = rd_ok & (cpu_addr_i == ADDR_WIDTH'(r));

      uart_csr_reg #(
         .DATA_WIDTH  (DATA_WIDTH),
         .RW_MASK     (RW_MASK[r*DATA_WIDTH +: DATA_WIDTH]),
         .RC_MASK     (RC_MASK[r*DATA_WIDTH +: DATA_WIDTH]),
         .W1C_MASK    (W1C_MASK[r*DATA_WIDTH +: DATA_WIDTH]),
         .RESET_VALUE (RESET_VALUE[r*DATA_WIDTH +: DATA_WIDTH])
      ) u_reg (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .cpu_wr      (wr_sel[r]),
         .cpu_rd      (rd_sel[r]),
         .be_mask     (be_mask),
         .cpu_data    (cpu_data_i),
         .periph_wr   (periph_wr_en_i[r]),
         .periph_data (periph_data_i[r*DATA_WIDTH +: DATA_WIDTH]),
         .periph_set  (periph_set_i[r*DATA_WIDTH +: DATA_WIDTH]),
         .q           (regs[r])
      );

      assign periph_data_o[r*DATA_WIDTH +: DATA_WIDTH] = regs[r];
   end

   // Unselected or out-of-range reads return zero.
   always_comb begin
      rd_mux = '0;
      for (int r = 0; r < REG_COUNT; r++) begin
         if (rd_sel[r]) rd_mux = regs[r];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cpu_data_o   <= '0;
         cpu_rvalid_o <= 1'b0;
         cpu_err_o    <= 1'b0;
         rd_strobe_o  <= '0;
         wr_strobe_o  <= '0;
         irq_o        <= 1'b0;
      end else begin
         cpu_rvalid_o <= rd_req;
         if (rd_req) cpu_data_o <= rd_mux;
         cpu_err_o    <= ((cpu_rd_en_i | cpu_wr_en_i) & ~addr_ok)
                       | (cpu_rd_en_i & cpu_wr_en_i);
         rd_strobe_o  <= rd_sel;
         wr_strobe_o  <= wr_sel;
         irq_o        <= |(regs[IRQ_STAT_IDX] & regs[IRQ_EN_IDX]);
      end
   end

endmodule
